cc_alu_seq: RTL and testbench

- Registered, multi-cycle successor to the combinational datapath ALU.
- Parametrised data width.
- Adds iterative shift/rotate ops on the previously spare opcodes, a start/done handshake, and a sticky flag register updated only on request.
- Sits between the register file read buses and the write-back bus of the datapath; the control unit drives its start strobe and waits for done.

---
 rtl/cc_alu_seq_pkg.sv | 44 ++++
 rtl/cc_alu_seq_shifter.sv | 48 ++++
 rtl/cc_alu_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_cc_alu_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cc_alu_seq_pkg.sv
// cc_alu_seq_pkg
// Purpose : shared opcode values, FSM state encoding and flag bit positions
//           for the sequential ALU (cc_alu_seq) and its shifter.
// Ports   : none (package).
// Config  : CC_ALU_SEQ_MUL_EN turns OP_PASS (1110) into a shift-add multiply.
package cc_alu_seq_pkg;

    localparam logic [3:0] OP_BUSA = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_NOTA = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_INC  = 4'b1010;
    localparam logic [3:0] OP_DEC  = 4'b1011;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_ROR  = 4'b1101;
    localparam logic [3:0] OP_PASS = 4'b1110;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit positions inside the active-low flag register.
    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_NEGATIVE = 1;
    localparam int FLAG_CARRY    = 2;
    localparam int FLAG_OVERFLOW = 3;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/cc_alu_seq_shifter.sv
// cc_alu_seq_shifter
// Purpose : combinational single-bit shift/rotate step; the parent FSM
//           applies it once per cycle.
// Ports   : op      - opcode selecting SLL/SRL/SRA/ROL/ROR (others pass data)
//           data    - value to step
//           shifted - data moved by one bit position
//           bit_out - bit that left the word on this step
module cc_alu_seq_shifter
    import cc_alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0] op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] shifted,
    output logic             bit_out
);

    always_comb begin
        shifted = data;
        bit_out = 1'b0;
        case (op)
            OP_SLL: begin
                shifted = {data[WIDTH-2:0], 1'b0};
                bit_out = data[WIDTH-1];
            end
            OP_SRL: begin
                shifted = {1'b0, data[WIDTH-1:1]};
                bit_out = data[0];
            end
            OP_SRA: begin
                shifted = {data[WIDTH-1], data[WIDTH-1:1]};
                bit_out = data[0];
            end
            OP_ROL: begin
                shifted = {data[WIDTH-2:0], data[WIDTH-1]};
                bit_out = data[WIDTH-1];
            end
            OP_ROR: begin
                shifted = {data[0], data[WIDTH-1:1]};
                bit_out = data[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cc_alu_seq.sv
// cc_alu_seq
// Purpose : registered multi-cycle ALU with start/done handshake, iterative
//           shift/rotate and a sticky active-low flag register.
// Ports   : CC_ALU_SEQ_CLOCK_50 / CC_ALU_SEQ_RESET_InLow - clock, async reset
//           CC_ALU_SEQ_start_InHigh, _setFlags_InHigh, _selection_InBUS,
//           _dataA_InBUS, _dataB_InBUS                    - request side
//           CC_ALU_SEQ_busy_OutHigh, _done_OutHigh, _data_OutBUS,
//           _overflow/_carry/_negative/_zero_OutLow        - result side
// Config  : define CC_ALU_SEQ_MUL_EN to make opcode 1110 an unsigned
//           shift-add multiply (low half of A*B, DATAWIDTH_BUS+1 cycles).
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | iterating one bit per cycle, counter holds steps left
// ST_MUL   | shift-add multiply step per cycle (CC_ALU_SEQ_MUL_EN only)
// ST_DONE  | result/flags just written, done pulse
module cc_alu_seq
    import cc_alu_seq_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_SHAMT         = 5
) (
    input  logic                               CC_ALU_SEQ_CLOCK_50,
    input  logic                               CC_ALU_SEQ_RESET_InLow,
    input  logic                               CC_ALU_SEQ_start_InHigh,
    input  logic                               CC_ALU_SEQ_setFlags_InHigh,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALU_SEQ_selection_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_dataA_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_dataB_InBUS,
    output logic                               CC_ALU_SEQ_busy_OutHigh,
    output logic                               CC_ALU_SEQ_done_OutHigh,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_data_OutBUS,
    output logic                               CC_ALU_SEQ_overflow_OutLow,
    output logic                               CC_ALU_SEQ_carry_OutLow,
    output logic                               CC_ALU_SEQ_negative_OutLow,
    output logic                               CC_ALU_SEQ_zero_OutLow
);

    localparam int W     = DATAWIDTH_BUS;
    localparam int CNT_W = DATAWIDTH_SHAMT + 1;

    state_t                               state_q, state_d;
    logic [DATAWIDTH_ALU_SELECTION-1:0]   op_q, op_d;
    logic                                 sf_q, sf_d;
    logic [W-1:0]                         work_q, work_d;
    logic [W-1:0]                         result_q, result_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [3:0]                           flags_q, flags_d;

    logic [W-1:0]                         a_in, b_in;
    logic [DATAWIDTH_SHAMT-1:0]           shamt_in;
    logic [W-1:0]                         alu_y, alu_res;
    logic [W:0]                           alu_sum;
    logic                                 alu_cin, alu_cmsb, alu_c, alu_v;

    logic [W-1:0]                         sh_data;
    logic                                 sh_bit;

    logic                                 fin, fin_write, fin_sf, fin_c, fin_v;
    logic [W-1:0]                         fin_res;

`ifdef CC_ALU_SEQ_MUL_EN
    logic [2*W-1:0]                       prod_q, prod_d, prod_step;
    logic [W:0]                           mul_sum;
`endif

    assign a_in     = CC_ALU_SEQ_dataA_InBUS;
    assign b_in     = CC_ALU_SEQ_dataB_InBUS;
    assign shamt_in = CC_ALU_SEQ_dataB_InBUS[DATAWIDTH_SHAMT-1:0];

    cc_alu_seq_shifter #(
        .WIDTH (W),
        .SEL_W (DATAWIDTH_ALU_SELECTION)
    ) u_shifter (
        .op      (op_q),
        .data    (work_q),
        .shifted (sh_data),
        .bit_out (sh_bit)
    );

    // One W+1 adder serves ADD/SUB/INC/DEC; SUB and DEC are A + ~operand + 1.
    always_comb begin
        alu_y   = b_in;
        alu_cin = 1'b0;
        case (CC_ALU_SEQ_selection_InBUS)
            OP_SUB: begin alu_y = ~b_in;  alu_cin = 1'b1; end
            OP_INC: begin alu_y = '0;     alu_cin = 1'b1; end
            OP_DEC: begin alu_y = '1;     alu_cin = 1'b0; end
            default: ;
        endcase
        alu_sum  = {1'b0, a_in} + {1'b0, alu_y} + (W+1)'(alu_cin);
        alu_cmsb = alu_sum[W-1] ^ a_in[W-1] ^ alu_y[W-1];

        alu_res = a_in;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (CC_ALU_SEQ_selection_InBUS)
            OP_OR:   alu_res = a_in | b_in;
            OP_AND:  alu_res = a_in & b_in;
            OP_NOTA: alu_res = ~a_in;
            OP_XOR:  alu_res = a_in ^ b_in;
            OP_ADD, OP_INC: begin
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
                alu_v   = alu_cmsb ^ alu_sum[W];
            end
            OP_SUB, OP_DEC: begin
                alu_res = alu_sum[W-1:0];
                alu_c   = ~alu_sum[W];
                alu_v   = alu_cmsb ^ alu_sum[W];
            end
            default: ;
        endcase
    end

`ifdef CC_ALU_SEQ_MUL_EN
    // Multiplier bits sit in the low half and are consumed LSB first.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, work_q} : '0);
        prod_step = {mul_sum, prod_q[W-1:1]};
    end
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sf_d      = sf_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        flags_d   = flags_q;
`ifdef CC_ALU_SEQ_MUL_EN
        prod_d    = prod_q;
`endif
        fin       = 1'b0;
        fin_write = 1'b1;
        fin_sf    = sf_q;
        fin_res   = work_q;
        fin_c     = 1'b0;
        fin_v     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CC_ALU_SEQ_start_InHigh) begin
                    op_d   = CC_ALU_SEQ_selection_InBUS;
                    sf_d   = CC_ALU_SEQ_setFlags_InHigh;
                    fin_sf = CC_ALU_SEQ_setFlags_InHigh;
                    if (is_shift_op(CC_ALU_SEQ_selection_InBUS)) begin
                        if (shamt_in == '0) begin
                            fin     = 1'b1;
                            fin_res = a_in;
                        end else begin
                            work_d  = a_in;
                            cnt_d   = {1'b0, shamt_in};
                            state_d = ST_SHIFT;
                        end
                    end
`ifdef CC_ALU_SEQ_MUL_EN
                    else if (CC_ALU_SEQ_selection_InBUS == OP_MUL) begin
                        work_d  = a_in;
                        prod_d  = {{W{1'b0}}, b_in};
                        cnt_d   = CNT_W'(W);
                        state_d = ST_MUL;
                    end
`endif
                    else begin
                        fin       = 1'b1;
                        fin_write = (CC_ALU_SEQ_selection_InBUS != OP_NOP);
                        fin_res   = alu_res;
                        fin_c     = alu_c;
                        fin_v     = alu_v;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = sh_data;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fin     = 1'b1;
                    fin_res = sh_data;
                    // Rotates never lose a bit, so they report no carry.
                    fin_c   = sh_bit & ~((op_q == OP_ROL) || (op_q == OP_ROR));
                end
            end
`ifdef CC_ALU_SEQ_MUL_EN
            ST_MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fin     = 1'b1;
                    fin_res = prod_step[W-1:0];
                    fin_c   = |prod_step[2*W-1:W];
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Result and flags are written on the edge entering ST_DONE so they
        // are already valid while done is high.
        if (fin) begin
            state_d = ST_DONE;
            if (fin_write) begin
                result_d = fin_res;
                if (fin_sf) begin
                    flags_d[FLAG_ZERO]     = |fin_res;
                    flags_d[FLAG_NEGATIVE] = ~fin_res[W-1];
                    flags_d[FLAG_CARRY]    = ~fin_c;
                    flags_d[FLAG_OVERFLOW] = ~fin_v;
                end
            end
        end
    end

    always_ff @(posedge CC_ALU_SEQ_CLOCK_50 or negedge CC_ALU_SEQ_RESET_InLow) begin
        if (!CC_ALU_SEQ_RESET_InLow) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sf_q     <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            flags_q  <= '1;
`ifdef CC_ALU_SEQ_MUL_EN
            prod_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sf_q     <= sf_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            flags_q  <= flags_d;
`ifdef CC_ALU_SEQ_MUL_EN
            prod_q   <= prod_d;
`endif
        end
    end

    assign CC_ALU_SEQ_busy_OutHigh    = (state_q == ST_SHIFT) || (state_q == ST_MUL);
    assign CC_ALU_SEQ_done_OutHigh    = (state_q == ST_DONE);
    assign CC_ALU_SEQ_data_OutBUS     = result_q;
    assign CC_ALU_SEQ_overflow_OutLow = flags_q[FLAG_OVERFLOW];
    assign CC_ALU_SEQ_carry_OutLow    = flags_q[FLAG_CARRY];
    assign CC_ALU_SEQ_negative_OutLow = flags_q[FLAG_NEGATIVE];
    assign CC_ALU_SEQ_zero_OutLow     = flags_q[FLAG_ZERO];

endmodule

// File: tb/tb_cc_alu_seq.sv
// tb_cc_alu_seq
// Purpose : directed + random check of cc_alu_seq at 8-bit width against an
//           independent behavioural model feeding a scoreboard queue.
// Config  : honours CC_ALU_SEQ_MUL_EN for the 1110 opcode expectation.
module tb_cc_alu_seq;

    localparam int W  = 8;
    localparam int SH = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         set_flags = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] data;
    logic         ovf_n, carry_n, neg_n, zero_n;

    wire  [3:0]   flags_obs = {ovf_n, carry_n, neg_n, zero_n};

    typedef struct {
        int         lat;
        logic [7:0] res;
        logic [3:0] flags;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_res = 8'h00;
    logic [3:0] m_flags = 4'hF;

    always #5 clk = ~clk;

    cc_alu_seq #(
        .DATAWIDTH_BUS           (W),
        .DATAWIDTH_ALU_SELECTION (4),
        .DATAWIDTH_SHAMT         (SH)
    ) dut (
        .CC_ALU_SEQ_CLOCK_50        (clk),
        .CC_ALU_SEQ_RESET_InLow     (rst_n),
        .CC_ALU_SEQ_start_InHigh    (start),
        .CC_ALU_SEQ_setFlags_InHigh (set_flags),
        .CC_ALU_SEQ_selection_InBUS (sel),
        .CC_ALU_SEQ_dataA_InBUS     (a),
        .CC_ALU_SEQ_dataB_InBUS     (b),
        .CC_ALU_SEQ_busy_OutHigh    (busy),
        .CC_ALU_SEQ_done_OutHigh    (done),
        .CC_ALU_SEQ_data_OutBUS     (data),
        .CC_ALU_SEQ_overflow_OutLow (ovf_n),
        .CC_ALU_SEQ_carry_OutLow    (carry_n),
        .CC_ALU_SEQ_negative_OutLow (neg_n),
        .CC_ALU_SEQ_zero_OutLow     (zero_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: updates m_res/m_flags, returns start-to-done latency.
    function automatic int model(input logic [3:0] op, input logic [7:0] x,
                                 input logic [7:0] y, input logic sf);
        logic [8:0]  full;
        logic [15:0] p;
        logic [7:0]  r;
        logic        c, v;
        int          s;
        int          lat;
        s   = int'(y[2:0]);
        lat = 1;
        r   = x;
        c   = 1'b0;
        v   = 1'b0;
        p   = '0;
        case (op)
            4'h0: r = x;
            4'h1: r = x | y;
            4'h2: r = x & y;
            4'h3: r = ~x;
            4'h4: r = x ^ y;
            4'h5: begin r = x << s; c = (s != 0) ? x[8-s] : 1'b0; lat = s + 1; end
            4'h6: begin r = x >> s; c = (s != 0) ? x[s-1] : 1'b0; lat = s + 1; end
            4'h7: begin r = 8'($signed(x) >>> s); c = (s != 0) ? x[s-1] : 1'b0; lat = s + 1; end
            4'hC: begin r = (x << s) | (x >> (8 - s)); lat = s + 1; end
            4'hD: begin r = (x >> s) | (x << (8 - s)); lat = s + 1; end
            4'h8: begin
                full = {1'b0, x} + {1'b0, y};
                r = full[7:0];
                c = full[8];
                v = (x[7] == y[7]) && (r[7] != x[7]);
            end
            4'h9: begin r = x - y; c = (x < y); v = (x[7] != y[7]) && (r[7] != x[7]); end
            4'hA: begin r = x + 8'd1; c = (x == 8'hFF); v = (x == 8'h7F); end
            4'hB: begin r = x - 8'd1; c = (x == 8'h00); v = (x == 8'h80); end
            4'hE: begin
`ifdef CC_ALU_SEQ_MUL_EN
                p   = x * y;
                r   = p[7:0];
                c   = |p[15:8];
                lat = 9;
`else
                r   = x;
`endif
            end
            default: return 1;
        endcase
        m_res = r;
        if (sf) m_flags = {~v, ~c, ~r[7], |r};
        return lat;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] x,
                          input logic [7:0] y, input logic sf, input logic poke);
        exp_t e;
        exp_t got;
        int   cyc;
        int   busy_n;
        int   extra;
        e.lat   = model(op, x, y, sf);
        e.res   = m_res;
        e.flags = m_flags;
        sb.push_back(e);

        sel = op; a = x; b = y; set_flags = sf; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom); set_flags = 1'($urandom);
        cyc = 1;
        busy_n = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_n++;
            if (poke && cyc == 2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        got = sb.pop_front();
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(got.lat));
        chk({tag, " busy cycles"}, 32'(busy_n), 32'(got.lat - 1));
        chk({tag, " result"}, 32'(data), 32'(got.res));
        chk({tag, " flags"}, 32'(flags_obs), 32'(got.flags));
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk({tag, " extra done"}, 32'(extra), 32'd0);
        chk({tag, " result held"}, 32'(data), 32'(got.res));
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset data", 32'(data), 32'h00);
        chk("reset flags", 32'(flags_obs), 32'hF);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add", 4'h8, 8'h7F, 8'h01, 1'b1, 1'b0);
        run_op("sub", 4'h9, 8'h00, 8'h01, 1'b1, 1'b0);
        run_op("sra", 4'h7, 8'h90, 8'h03, 1'b1, 1'b1);
        run_op("ror", 4'hD, 8'h01, 8'h01, 1'b1, 1'b0);
        run_op("sll0", 4'h5, 8'h5A, 8'h00, 1'b1, 1'b0);
        run_op("and_nf", 4'h2, 8'h0F, 8'hF0, 1'b0, 1'b0);
        run_op("op1110", 4'hE, 8'h10, 8'h11, 1'b1, 1'b0);
        run_op("nop", 4'hF, 8'hAA, 8'h55, 1'b1, 1'b0);
        run_op("inc", 4'hA, 8'hFF, 8'h00, 1'b1, 1'b0);

        // Reset in the middle of a 7-step shift.
        sel = 4'h5; a = 8'h81; b = 8'h07; set_flags = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid reset data", 32'(data), 32'h00);
        chk("mid reset flags", 32'(flags_obs), 32'hF);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_res = 8'h00;
        m_flags = 4'hF;
        n = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk("mid reset no done", 32'(n), 32'd0);
        chk("mid reset data after", 32'(data), 32'h00);

        for (int i = 0; i < 14; i++) begin
            run_op("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                   1'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
